regfile_port_sequencer: RTL and testbench
=========================================

# regfile_port_sequencer

Sequencer that sits directly upstream of the register-file cell array. It accepts one register-access request per transaction (two reads, one optional write) over a valid/ready handshake. It drives the array's one-hot read-enables (ReadA/ReadB), one-hot write strobes (WS) and shared write-data bus (In), then captures the tri-stated read buses into registered operands. It returns those operands to the consumer over a second valid/ready handshake.

## Interface
- N, 32, data width of each register and of all data buses
- DEPTH, 32, number of registers in the array (one-hot select width)
- AW, 5, address width, log2(DEPTH)

- Clk  input  1  single clock; all state updates on rising edge
- Rst  input  1  synchronous, active-high reset
- ReqValid  input  1  request present
- ReqReady  output  1  sequencer can accept a request
- RA  input  AW  read address, port A
- RB  input  AW  read address, port B
- WE  input  1  request includes a write
- WA  input  AW  write address
- WD  input  N  write data
- ReadA  output  DEPTH  one-hot bus-A enable to array
- ReadB  output  DEPTH  one-hot bus-B enable to array
- WS  output  DEPTH  one-hot write strobe to array
- In  output  N  write data to array
- BusA  input  N  shared tri-state read bus A from array
- BusB  input  N  shared tri-state read bus B from array
- OpA  output  N  captured operand A
- OpB  output  N  captured operand B
- OutValid  output  1  OpA/OpB valid
- OutReady  input  1  consumer accepts operands

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: ReqReady=1. On ReqValid&ReqReady, latch RA, RB, WE, WA and WD into internal registers, then go to READ.
- READ: ReadA = onehot(RA_q) and ReadB = onehot(RB_q). At the closing edge, OpA<=BusA and OpB<=BusB, then go to WRITE.
- Register 0 reads as zero. If RA_q==0, ReadA is all-zero (bus not driven) and OpA<=0 regardless of BusA. The same rule applies to port B.
- WRITE: In=WD_q. WS=onehot(WA_q) only if WE_q=1 and WA_q!=0; otherwise WS=0. The array commits at the closing edge. Then go to DONE.
- DONE: OutValid=1 and OpA/OpB are held stable. On OutReady, go to IDLE.
- Read-before-write: a request whose RA or RB equals WA returns the pre-write value. Bypass is not required because the read completes a cycle before WS is asserted.
- The same address on both read ports is legal; both enables select the same cell.
- ReadA, ReadB and WS are combinational decodes of state and latched fields, gated by !Rst. At most one bit of each is high. All are zero outside their state.
- In holds WD_q in every state; it is 0 after reset until the first accept.

## Timing
- Reset: with Rst high at an edge, the next state is IDLE, OpA=OpB=0, OutValid=0, and the latched fields are cleared. ReqReady=0 while Rst is high, and 1 in the first cycle after Rst deasserts.
- Reset mid-transaction: the transaction is abandoned and no OutValid is produced. If Rst is high during the WRITE cycle, WS is forced to 0 and the array is not written.
- Latency: request accepted at edge E0, ReadA/ReadB high in cycle E0..E1, operands captured at E1, WS high in cycle E1..E2, OutValid=1 from E2.
- Throughput: at most one request per 4 cycles. DONE→IDLE takes one edge, and ReqReady is low in READ, WRITE and DONE.
- OutValid, once asserted, stays high with OpA/OpB unchanged until the edge where OutReady=1 (no retraction).
- ReqValid during READ, WRITE or DONE is ignored; the requester must hold it until ReqReady.
- The OutReady handshake completes at the edge sampled in DONE. OutReady in other states has no effect.

## Test plan
- Reset: hold Rst for 2 cycles mid-DONE → OutValid=0, OpA=OpB=0, ReadA=ReadB=WS=0; ReqReady=1 the cycle after release.
- Write then read: request WE=1, WA=5, WD=0xDEADBEEF, then a request with RA=5, RB=0 → second response OpA=0xDEADBEEF, OpB=0; WS=0x20 for exactly one cycle.
- Read-before-write: array r7=0x11 and request RA=7, WE=1, WA=7, WD=0x22 → OpA=0x11; a follow-up read of 7 returns 0x22.
- Register 0: WE=1, WA=0, WD=0xFFFF → WS stays 0; a read of RA=0 gives ReadA=0 and OpA=0 even with BusA forced to 0xAAAA.
- Backpressure: hold OutReady=0 for 10 cycles → OutValid stays 1, OpA/OpB stable, ReqReady=0; release → IDLE next cycle.
- Reset in WRITE: assert Rst during the WRITE cycle of WA=3, WD=0x55 → WS=0 that cycle; a later read of r3 returns its prior value.

Source files
------------

// File: rtl/regfile_port_sequencer_if.sv
// Bundle of request, array-side and response signals between the register-file
// sequencer (master) and its requester/array/consumer environment (slave).
interface regfile_port_sequencer_if #(
   parameter int N     = 32,
   parameter int DEPTH = 32,
   parameter int AW    = 5
);
   logic             ReqValid;
   logic             ReqReady;
   logic [AW-1:0]    RA;
   logic [AW-1:0]    RB;
   logic             WE;
   logic [AW-1:0]    WA;
   logic [N-1:0]     WD;
   logic [DEPTH-1:0] ReadA;
   logic [DEPTH-1:0] ReadB;
   logic [DEPTH-1:0] WS;
   logic [N-1:0]     In;
   logic [N-1:0]     BusA;
   logic [N-1:0]     BusB;
   logic [N-1:0]     OpA;
   logic [N-1:0]     OpB;
   logic             OutValid;
   logic             OutReady;

   modport master (
      input  ReqValid, RA, RB, WE, WA, WD, BusA, BusB, OutReady,
      output ReqReady, ReadA, ReadB, WS, In, OpA, OpB, OutValid
   );

   modport slave (
      output ReqValid, RA, RB, WE, WA, WD, BusA, BusB, OutReady,
      input  ReqReady, ReadA, ReadB, WS, In, OpA, OpB, OutValid
   );
endinterface

// File: rtl/regfile_port_sequencer.sv
// Four-state sequencer: latches a two-read/one-write request, drives the cell
// array's one-hot enables, captures both read buses and hands the operands on.
module regfile_port_sequencer #(
   parameter int N     = 32,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic                      Clk,
   input  logic                      Rst,
   regfile_port_sequencer_if.master  io_bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]    r_state;
   logic [AW-1:0] r_ra;
   logic [AW-1:0] r_rb;
   logic          r_we;
   logic [AW-1:0] r_wa;
   logic [N-1:0]  r_wd;
   logic [N-1:0]  r_opa;
   logic [N-1:0]  r_opb;

   logic          w_in_read;
   logic          w_in_write;
   logic [DEPTH-1:0] w_read_a;
   logic [DEPTH-1:0] w_read_b;
   logic [DEPTH-1:0] w_ws;

   assign w_in_read  = !Rst && (r_state == S_READ);
   assign w_in_write = !Rst && (r_state == S_WRITE) && r_we;

   // Register 0 is hard-wired zero: its enables never fire, so the bus is never driven for it.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_decode
      if (gi == 0) begin : g_zero
         assign w_read_a[gi] = 1'b0;
         assign w_read_b[gi] = 1'b0;
         assign w_ws[gi]     = 1'b0;
      end else begin : g_cell
         assign w_read_a[gi] = w_in_read  && (r_ra == AW'(gi));
         assign w_read_b[gi] = w_in_read  && (r_rb == AW'(gi));
         assign w_ws[gi]     = w_in_write && (r_wa == AW'(gi));
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state <= S_IDLE;
         r_ra    <= '0;
         r_rb    <= '0;
         r_we    <= 1'b0;
         r_wa    <= '0;
         r_wd    <= '0;
         r_opa   <= '0;
         r_opb   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (io_bus.ReqValid) begin
                  r_ra    <= io_bus.RA;
                  r_rb    <= io_bus.RB;
                  r_we    <= io_bus.WE;
                  r_wa    <= io_bus.WA;
                  r_wd    <= io_bus.WD;
                  r_state <= S_READ;
               end
            end
            S_READ: begin
               r_opa   <= (r_ra == '0) ? '0 : io_bus.BusA;
               r_opb   <= (r_rb == '0) ? '0 : io_bus.BusB;
               r_state <= S_WRITE;
            end
            S_WRITE: begin
               r_state <= S_DONE;
            end
            default: begin
               if (io_bus.OutReady) begin
                  r_state <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign io_bus.ReqReady = !Rst && (r_state == S_IDLE);
   assign io_bus.ReadA    = w_read_a;
   assign io_bus.ReadB    = w_read_b;
   assign io_bus.WS       = w_ws;
   assign io_bus.In       = r_wd;
   assign io_bus.OpA      = r_opa;
   assign io_bus.OpB      = r_opb;
   assign io_bus.OutValid = (r_state == S_DONE);
endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Bench for regfile_port_sequencer: a cell-array model answers the read buses,
// and a transaction-level register map predicts every operand and strobe.
module tb_regfile_port_sequencer;
   localparam int N     = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam logic [N-1:0] BUS_IDLE = 32'h0000_AAAA;

   logic Clk;
   logic Rst;
   int   n_checks;
   int   n_errors;

   logic [N-1:0] arr     [DEPTH];
   logic [N-1:0] ref_mem [DEPTH];

   regfile_port_sequencer_if #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_if ();

   regfile_port_sequencer #(.N(N), .DEPTH(DEPTH), .AW(AW)) u_dut (
      .Clk    (Clk),
      .Rst    (Rst),
      .io_bus (u_if.master)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Cell array: commits on WS at the rising edge, drives buses from enables.
   always @(posedge Clk) begin
      for (int i = 0; i < DEPTH; i++)
         if (u_if.WS[i]) arr[i] <= u_if.In;
   end

   always_comb begin
      u_if.BusA = BUS_IDLE;
      u_if.BusB = BUS_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
         if (u_if.ReadA[i]) u_if.BusA = arr[i];
         if (u_if.ReadB[i]) u_if.BusB = arr[i];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [DEPTH-1:0] onehot(input logic [AW-1:0] a);
      logic [DEPTH-1:0] v;
      v = '0;
      if (a != 0) v[a] = 1'b1;
      return v;
   endfunction

   // rst_mode: 0 normal, 1 reset for two cycles while in DONE, 2 reset during WRITE
   task automatic txn(input logic [AW-1:0] ra, input logic [AW-1:0] rb, input logic we,
                      input logic [AW-1:0] wa, input logic [N-1:0] wd,
                      input int stall, input int rst_mode);
      logic [N-1:0] ea, eb;
      int guard;
      ea = (ra == 0) ? '0 : ref_mem[ra];
      eb = (rb == 0) ? '0 : ref_mem[rb];
      u_if.ReqValid = 1'b1;
      u_if.RA = ra; u_if.RB = rb; u_if.WE = we; u_if.WA = wa; u_if.WD = wd;
      guard = 0;
      while (u_if.ReqReady !== 1'b1 && guard < 20) begin
         @(posedge Clk); #1; guard++;
      end
      chk("req_ready_idle", u_if.ReqReady, 1);
      @(posedge Clk); #1;
      // READ: scramble request inputs; nothing may be re-latched or handshaken
      u_if.ReqValid = 1'($urandom); u_if.RA = AW'($urandom); u_if.RB = AW'($urandom);
      u_if.WE = 1'($urandom); u_if.WA = AW'($urandom); u_if.WD = $urandom;
      u_if.OutReady = 1'($urandom);
      #1;
      chk("read_a", u_if.ReadA, onehot(ra));
      chk("read_b", u_if.ReadB, onehot(rb));
      chk("ws_in_read", u_if.WS, 0);
      chk("req_ready_busy", u_if.ReqReady, 0);
      @(posedge Clk); #1;
      // WRITE
      if (rst_mode == 2) begin
         Rst = 1'b1; #1;
         chk("ws_under_rst", u_if.WS, 0);
         chk("req_ready_rst", u_if.ReqReady, 0);
         @(posedge Clk); #1;
         Rst = 1'b0; u_if.ReqValid = 1'b0; u_if.OutReady = 1'b0; #1;
         chk("out_valid_after_rst", u_if.OutValid, 0);
         chk("req_ready_after_rst", u_if.ReqReady, 1);
         return;
      end
      chk("ws", u_if.WS, (we && wa != 0) ? onehot(wa) : '0);
      chk("in", u_if.In, wd);
      chk("read_a_in_write", u_if.ReadA, 0);
      if (we && wa != 0) ref_mem[wa] = wd;
      @(posedge Clk); #1;
      // DONE
      u_if.ReqValid = 1'b0;
      u_if.OutReady = (stall == 0) ? 1'b1 : 1'b0;
      chk("ws_in_done", u_if.WS, 0);
      chk("out_valid", u_if.OutValid, 1);
      chk("op_a", u_if.OpA, ea);
      chk("op_b", u_if.OpB, eb);
      if (rst_mode == 1) begin
         u_if.OutReady = 1'b0;
         Rst = 1'b1;
         @(posedge Clk); #1;
         @(posedge Clk); #1;
         chk("rst_out_valid", u_if.OutValid, 0);
         chk("rst_op_a", u_if.OpA, 0);
         chk("rst_op_b", u_if.OpB, 0);
         chk("rst_enables", {u_if.ReadA, u_if.ReadB, u_if.WS} == '0, 1);
         chk("rst_req_ready", u_if.ReqReady, 0);
         chk("rst_in", u_if.In, 0);
         Rst = 1'b0; #1;
         chk("req_ready_release", u_if.ReqReady, 1);
         return;
      end
      for (int s = 0; s < stall; s++) begin
         @(posedge Clk); #1;
         chk("hold_out_valid", u_if.OutValid, 1);
         chk("hold_op_a", u_if.OpA, ea);
         chk("hold_op_b", u_if.OpB, eb);
         chk("hold_req_ready", u_if.ReqReady, 0);
      end
      u_if.OutReady = 1'b1;
      @(posedge Clk); #1;
      u_if.OutReady = 1'b0;
      chk("out_valid_drop", u_if.OutValid, 0);
      chk("req_ready_back", u_if.ReqReady, 1);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < DEPTH; i++) begin
         arr[i] = '0;
         ref_mem[i] = '0;
      end
      Rst = 1'b1;
      u_if.ReqValid = 1'b0; u_if.RA = '0; u_if.RB = '0; u_if.WE = 1'b0;
      u_if.WA = '0; u_if.WD = '0; u_if.OutReady = 1'b0;
      @(posedge Clk); #1;
      @(posedge Clk); #1;
      chk("reset_req_ready", u_if.ReqReady, 0);
      chk("reset_out_valid", u_if.OutValid, 0);
      chk("reset_op_a", u_if.OpA, 0);
      chk("reset_in", u_if.In, 0);
      chk("reset_enables", {u_if.ReadA, u_if.ReadB, u_if.WS} == '0, 1);
      Rst = 1'b0; #1;
      chk("reset_release_ready", u_if.ReqReady, 1);

      // Write then read back
      txn(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 0, 0);
      txn(5'd5, 5'd0, 1'b0, 5'd0, 32'h0, 0, 0);
      // Read-before-write on r7, then follow-up read
      txn(5'd0, 5'd0, 1'b1, 5'd7, 32'h11, 0, 0);
      txn(5'd7, 5'd7, 1'b1, 5'd7, 32'h22, 0, 0);
      txn(5'd7, 5'd5, 1'b0, 5'd0, 32'h0, 0, 0);
      // Register 0 is never written and reads zero despite the idle bus value
      txn(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF, 0, 0);
      txn(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 0, 0);
      // Backpressure
      txn(5'd5, 5'd7, 1'b0, 5'd0, 32'h0, 10, 0);
      // Reset during WRITE leaves r3 at its prior value
      txn(5'd0, 5'd0, 1'b1, 5'd3, 32'h33, 0, 0);
      txn(5'd0, 5'd0, 1'b1, 5'd3, 32'h55, 0, 2);
      txn(5'd3, 5'd0, 1'b0, 5'd0, 32'h0, 0, 0);
      // Reset held two cycles while in DONE
      txn(5'd5, 5'd3, 1'b1, 5'd9, 32'h1234_5678, 0, 1);
      txn(5'd9, 5'd3, 1'b0, 5'd0, 32'h0, 0, 0);

      for (int t = 0; t < 60; t++) begin
         txn(AW'($urandom), AW'($urandom), 1'($urandom), AW'($urandom),
             $urandom, int'($urandom_range(0, 3)), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
